ysyx_25020047_lsu: RTL and testbench

- Load/store unit that services the EXU's memory requests (read/write strobe, computed address, store data) against a multi-cycle SRAM-style data bus.
- Core-facing valid/ready request channel, bus-facing request/response channel.
- Handles word and byte accesses (lw, lbu, sw, sb): byte-lane strobes, read-data extraction, misalignment and bus-timeout errors.
- Sits between EXU/WBU and the data memory; the core stalls while req_ready or resp_valid is pending.

---
 rtl/ysyx_25020047_lsu.sv | 111 +++++++++++
 tb/tb_ysyx_25020047_lsu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one core memory request at a time and runs it on a
// multi-cycle SRAM-style bus, with byte strobes, misalignment and timeout errors.
module ysyx_25020047_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [31:0] addr_q, wdata_q;
   logic        size_q, write_q;
   logic [15:0] cnt_q;
   logic [31:0] load_data;
   logic        accept, misaligned, timeout_hit;

   assign req_ready   = rst_n && (state == IDLE);
   assign mem_valid   = (state == ISSUE);
   assign resp_valid  = (state == RESP);
   assign accept      = req_valid && req_ready;
   assign misaligned  = req_size && (req_addr[1:0] != 2'b00);
   assign timeout_hit = (cnt_q == CNT_LAST);

   // Bus fields come only from captured flops, so they hold steady through an ISSUE stall.
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wen   = write_q;
   assign mem_wdata = size_q ? wdata_q : {4{wdata_q[7:0]}};
   assign mem_wstrb = !write_q ? 4'b0000 : (size_q ? 4'b1111 : 4'b0001 << addr_q[1:0]);
   assign load_data = size_q ? mem_rdata : {24'b0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};

   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = misaligned ? RESP : ISSUE;
         ISSUE:   if (mem_ready) state_nxt = (write_q || mem_rvalid) ? RESP : WAIT;
         WAIT:    if (mem_rvalid || timeout_hit) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= 1'b0;
         write_q    <= 1'b0;
         cnt_q      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               addr_q     <= req_addr;
               wdata_q    <= req_wdata;
               size_q     <= req_size;
               write_q    <= req_write;
               resp_rdata <= '0;
               resp_err   <= misaligned;
            end
            ISSUE: if (mem_ready) begin
               cnt_q    <= '0;
               resp_err <= 1'b0;
               if (!write_q && mem_rvalid) resp_rdata <= load_data;
            end
            WAIT: begin
               cnt_q <= cnt_q + 16'd1;
               // Data arriving in the final counted cycle still beats the timeout.
               if (mem_rvalid) begin
                  resp_rdata <= load_data;
                  resp_err   <= 1'b0;
               end else if (timeout_hit) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for the LSU: a stimulus task predicts bus requests and core
// responses from a reference memory; a bus responder and a response monitor compare.
module tb_ysyx_25020047_lsu;

   localparam int TIMEOUT = 4;
   localparam int NEVER   = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, req_write, req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   ysyx_25020047_lsu #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          rdy;   // cycles mem_ready is withheld
      int          dly;   // cycles from handshake to mem_rvalid; NEVER = no data
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;   // cycle number of the accepting IDLE cycle
      int          lat;   // expected cycles from accept to first resp_valid
      int          stall; // cycles resp_ready held low; -1 = random
   } resp_t;

   bus_t        bus_q[$];
   resp_t       exp_q[$];
   logic [31:0] ref_mem[int unsigned];
   logic [31:0] bus_mem[int unsigned];
   int          passed = 0;
   int          total = 0;
   int          cyc = 0;
   bit          bus_auto = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(int unsigned k);
      return (k * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Issue one request and record what the bus and the core should see.
   task automatic do_txn(bit wr, bit sz, logic [31:0] a, logic [31:0] wd,
                         int rdy, int dly, int stall);
      resp_t       e;
      bus_t        b;
      int unsigned k;
      int          lane;
      logic [31:0] w;
      int          waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         check("req_ready_wait", {31'b0, req_ready}, 32'd1);
         return;
      end
      req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
      k    = 32'(a[31:2]);
      lane = int'(a[1:0]);
      w    = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
      e.acc = cyc; e.stall = stall; e.rdata = '0; e.err = 1'b0;
      if (sz && a[1:0] != 2'b00) begin
         e.err = 1'b1;
         e.lat = 1;
      end else begin
         b.addr = {a[31:2], 2'b00}; b.wen = wr; b.rdy = rdy; b.dly = dly;
         if (wr) begin
            b.wstrb = sz ? 4'hF : 4'(1 << lane);
            b.wdata = sz ? wd : {4{wd[7:0]}};
            if (sz) w = wd;
            else    w[8*lane +: 8] = wd[7:0];
            ref_mem[k] = w;
            e.lat = 2 + rdy;
         end else begin
            b.wstrb = 4'h0;
            b.wdata = '0;
            if (dly > TIMEOUT) begin
               e.err = 1'b1;
               e.lat = 2 + rdy + TIMEOUT;
            end else begin
               e.rdata = sz ? w : ((w >> (8*lane)) & 32'hFF);
               e.lat   = 2 + rdy + dly;
            end
         end
         bus_q.push_back(b);
      end
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Bus responder: serves one planned transaction at a time from its own memory.
   initial begin : responder
      bus_t        b;
      int unsigned k;
      logic [31:0] w;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         if (bus_auto && rst_n === 1'b1 && mem_valid === 1'b1) begin
            if (bus_q.size() == 0) begin
               check("unexpected_mem_valid", {31'b0, mem_valid}, 32'd0);
               @(negedge clk);
            end else begin
               b = bus_q.pop_front();
               repeat (b.rdy) @(negedge clk);
               check("mem_addr", mem_addr, b.addr);
               check("mem_wen", {31'b0, mem_wen}, {31'b0, b.wen});
               check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, b.wstrb});
               if (b.wen) check("mem_wdata", mem_wdata, b.wdata);
               k = 32'(b.addr[31:2]);
               w = bus_mem.exists(k) ? bus_mem[k] : init_word(k);
               mem_ready = 1'b1;
               if (b.wen) begin
                  for (int i = 0; i < 4; i++)
                     if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                  bus_mem[k] = w;
               end else if (b.dly == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = w;
               end
               @(negedge clk);
               mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
               if (!b.wen && b.dly > 0 && b.dly < NEVER) begin
                  repeat (b.dly - 1) @(negedge clk);
                  mem_rvalid = 1'b1;
                  mem_rdata  = (b.dly > TIMEOUT) ? 32'h1234_5678 : w;
                  @(negedge clk);
                  mem_rvalid = 1'b0; mem_rdata = $urandom;
               end
            end
         end else begin
            @(negedge clk);
            mem_rdata = $urandom;
         end
      end
   end

   // Response monitor: compares every resp_valid cycle against the queue head.
   initial begin : monitor
      resp_t e;
      int    seen = 0;
      bit    r;
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         resp_ready = 1'b0;
         if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_resp_valid", {31'b0, resp_valid}, 32'd0);
               resp_ready = 1'b1;
            end else begin
               e = exp_q[0];
               if (seen == 0) check("resp_latency", cyc - e.acc, e.lat);
               check("resp_rdata", resp_rdata, e.rdata);
               check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
               r = (e.stall >= 0) ? (seen >= e.stall) : ($urandom_range(0, 2) != 0);
               seen++;
               resp_ready = r;
               if (r) begin
                  void'(exp_q.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size() + bus_q.size(), 32'd0);
   endtask

   initial begin : stimulus
      logic [31:0] a;
      bit          sz;
      req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
      req_addr = '0; req_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      rst_n = 1'b1;
      #1 check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

      ref_mem[32'h2000_0000] = 32'h11C3_2244;
      bus_mem[32'h2000_0000] = 32'h11C3_2244;

      do_txn(1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, -1);     // sw, 2-cycle latency
      do_txn(1, 0, 32'h8000_0013, 32'h0000_00A5, 0, 0, -1);     // sb, lane 3
      do_txn(0, 1, 32'h8000_0010, 32'h0, 1, 2, -1);             // lw readback
      do_txn(0, 0, 32'h8000_0002, 32'h0, 0, 3, -1);             // lbu -> 0xC3
      do_txn(0, 1, 32'h8000_0006, 32'h0, 0, 0, -1);             // misaligned lw
      do_txn(1, 1, 32'h8000_0005, 32'hFFFF_FFFF, 0, 0, -1);     // misaligned sw
      do_txn(0, 1, 32'h8000_0020, 32'h0, 0, NEVER, 0);          // timeout
      do_txn(0, 1, 32'h8000_0024, 32'h0, 0, 6, 0);              // timeout, late data in IDLE
      do_txn(0, 1, 32'h8000_0028, 32'h0, 1, TIMEOUT, -1);       // data in final cycle wins
      do_txn(0, 0, 32'h8000_0029, 32'h0, 0, TIMEOUT + 1, -1);   // one cycle too late
      drain();

      for (int n = 0; n < 200; n++) begin
         sz = 1'($urandom_range(0, 1));
         a  = 32'h8000_0000 | {26'b0, 6'($urandom_range(0, 63))};
         if (sz && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         do_txn(1'($urandom_range(0, 1)), sz, a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, NEVER), -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      // Stalled response, then reset while the next request sits in ISSUE.
      do_txn(0, 1, 32'h8000_0010, 32'h0, 0, 1, 5);
      @(negedge clk);
      for (int n = 0; n < 300 && !req_ready; n++) @(negedge clk);
      bus_auto  = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_addr = 32'h8000_0030;
      @(negedge clk);
      req_valid = 1'b0;
      check("issue_mem_valid", {31'b0, mem_valid}, 32'd1);
      repeat (2) @(negedge clk);
      check("issue_stall_mem_valid", {31'b0, mem_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
      check("postrst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("postrst_resp_valid", {31'b0, resp_valid}, 32'd0);
      bus_auto = 1'b1;
      do_txn(0, 0, 32'h8000_0013, 32'h0, 1, 2, -1);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d of %0d passed", passed, total);
      $fatal(1);
   end

endmodule
